// File: rtl/program_loader.sv
// Program loader: streams a program image into ram, then releases the cpu.
// Optional LOADER_CHECKSUM_EN adds a running checksum output port.
module program_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              ram_w_en_q, ram_w_en_d;
  logic [ADDR_W-1:0] ram_w_addr_q, ram_w_addr_d;
  logic [DATA_W-1:0] ram_w_data_q, ram_w_data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

  logic accept;

  assign in_ready = (state_q == S_LOAD) && (word_count_q < MAX_CNT);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    addr_ptr_d   = addr_ptr_q;
    start_pc_d   = start_pc_q;
    word_count_d = word_count_q;
    ram_w_en_d   = 1'b0;
    ram_w_addr_d = ram_w_addr_q;
    ram_w_data_d = ram_w_data_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d      = S_LOAD;
          addr_ptr_d   = load_base;
          start_pc_d   = load_base;
          word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        if (accept) begin
          ram_w_en_d   = 1'b1;
          ram_w_addr_d = addr_ptr_q;
          ram_w_data_d = in_data;
          addr_ptr_d   = addr_ptr_q + ADDR_W'(1);
          word_count_d = word_count_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = checksum_q + in_data;
`endif
          if (in_last) begin
            state_d = S_FLUSH;
          end
        end else if (in_valid) begin
          // in_ready is low only once the word budget is exhausted
          state_d = S_ERR;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_ptr_q   <= '0;
      start_pc_q   <= '0;
      word_count_q <= '0;
      ram_w_en_q   <= 1'b0;
      ram_w_addr_q <= '0;
      ram_w_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_ptr_q   <= addr_ptr_d;
      start_pc_q   <= start_pc_d;
      word_count_q <= word_count_d;
      ram_w_en_q   <= ram_w_en_d;
      ram_w_addr_q <= ram_w_addr_d;
      ram_w_data_q <= ram_w_data_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  assign ram_w_en     = ram_w_en_q;
  assign ram_w_addr   = ram_w_addr_q;
  assign ram_w_data   = ram_w_data_q;
  assign cpu_rst_n    = (state_q == S_RUN);
  assign start_pc     = start_pc_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign done         = (state_q == S_RUN);
  assign err_overflow = (state_q == S_ERR);
  assign word_count   = word_count_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum     = checksum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: image streams checked against a word-list model.
// Built with MAX_WORDS=4 so the overflow path is reachable.
module tb_program_loader;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          ram_w_en;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          cpu_rst_n;
  logic [AW-1:0] start_pc;
  logic          busy;
  logic          done;
  logic          err_overflow;
  logic [AW:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  program_loader #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_WORDS(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .load_base(load_base),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .ram_w_en(ram_w_en),
    .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data),
    .cpu_rst_n(cpu_rst_n),
    .start_pc(start_pc),
    .busy(busy),
    .done(done),
    .err_overflow(err_overflow),
    .word_count(word_count)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [DW-1:0] img[$];
  logic [DW-1:0] exp_sum;

  always @(negedge clk) if (ram_w_en === 1'b1) wr_cnt++;

  task automatic pulse_start(input logic [AW-1:0] b);
    start = 1'b1;
    load_base = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit last,
                           input bit gap, input logic [AW-1:0] exp_addr);
    int budget = 20;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    while (in_ready !== 1'b1 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    checks++;
    if (ram_w_en !== 1'b1 || ram_w_addr !== exp_addr || ram_w_data !== d) begin
      errors++;
      $display("FAIL write en=%b addr=%h data=%h required 1 %h %h",
               ram_w_en, ram_w_addr, ram_w_data, exp_addr, d);
    end
  endtask

  task automatic run_image(input logic [AW-1:0] base, input bit gap,
                           input bit poke);
    int w0;
    logic [AW-1:0] a;
    w0 = wr_cnt;
    exp_sum = '0;
    pulse_start(base);
    checks++;
    if (busy !== 1'b1 || cpu_rst_n !== 1'b0 || start_pc !== base ||
        word_count !== 0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL start busy=%b cpu_rst_n=%b pc=%h wc=%0d err=%b required 1 0 %h 0 0",
               busy, cpu_rst_n, start_pc, word_count, err_overflow, base);
    end
    foreach (img[i]) begin
      a = base + AW'(i);
      push_word(img[i], i == img.size() - 1, gap, a);
      exp_sum = exp_sum + img[i];
      if (poke && i == 0 && img.size() > 1) pulse_start(~base);
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL flush busy=%b done=%b cpu_rst_n=%b required 1 0 0",
               busy, done, cpu_rst_n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0 ||
        start_pc !== base || word_count !== (AW+1)'(img.size())) begin
      errors++;
      $display("FAIL run done=%b cpu_rst_n=%b busy=%b pc=%h wc=%0d required 1 1 0 %h %0d",
               done, cpu_rst_n, busy, start_pc, word_count, base, img.size());
    end
    checks++;
    if (wr_cnt - w0 !== img.size()) begin
      errors++;
      $display("FAIL write_count got=%0d required %0d", wr_cnt - w0, img.size());
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== exp_sum) begin
      errors++;
      $display("FAIL checksum got=%h required %h", checksum, exp_sum);
    end
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (ram_w_en !== 1'b0 || ram_w_addr !== '0 || ram_w_data !== '0 ||
        cpu_rst_n !== 1'b0 || start_pc !== '0 || word_count !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || err_overflow !== 1'b0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset en=%b addr=%h data=%h crn=%b pc=%h wc=%0d b=%b d=%b e=%b rdy=%b required all 0",
               ram_w_en, ram_w_addr, ram_w_data, cpu_rst_n, start_pc,
               word_count, busy, done, err_overflow, in_ready);
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      errors++;
      $display("FAIL reset_checksum got=%h required 0", checksum);
    end
`endif
  endtask

  task automatic test_basic();
    img = '{16'h1111, 16'h2222, 16'h3333};
    run_image(8'h10, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    img = '{16'h1111, 16'h2222, 16'h3333};
    run_image(8'h10, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    img.delete();
    repeat (4) img.push_back(DW'($urandom));
    run_image(8'hFE, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int w0;
    logic [AW-1:0] a;
    w0 = wr_cnt;
    pulse_start(8'h20);
    for (int i = 0; i < MW; i++) begin
      a = 8'h20 + AW'(i);
      push_word(DW'($urandom), 1'b0, 1'b0, a);
    end
    in_valid = 1'b1;
    in_data = 16'hDEAD;
    checks++;
    if (in_ready !== 1'b0 || word_count !== (AW+1)'(MW)) begin
      errors++;
      $display("FAIL full_ready rdy=%b wc=%0d required 0 %0d",
               in_ready, word_count, MW);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (err_overflow !== 1'b1 || cpu_rst_n !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL overflow err=%b crn=%b busy=%b done=%b required 1 0 0 0",
               err_overflow, cpu_rst_n, busy, done);
    end
    checks++;
    if (wr_cnt - w0 !== MW) begin
      errors++;
      $display("FAIL overflow_writes got=%0d required %0d", wr_cnt - w0, MW);
    end
    img = '{16'hBEEF};
    run_image(8'h30, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midload();
    int w0;
    pulse_start(8'h50);
    push_word(16'hAAAA, 1'b0, 1'b0, 8'h50);
    push_word(16'hBBBB, 1'b0, 1'b0, 8'h51);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (ram_w_en !== 1'b0 || ram_w_addr !== '0 || ram_w_data !== '0 ||
        cpu_rst_n !== 1'b0 || start_pc !== '0 || word_count !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset en=%b addr=%h data=%h crn=%b pc=%h wc=%0d b=%b d=%b e=%b required all 0",
               ram_w_en, ram_w_addr, ram_w_data, cpu_rst_n, start_pc,
               word_count, busy, done, err_overflow);
    end
    w0 = wr_cnt;
    in_valid = 1'b1;
    in_data = 16'hCCCC;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ready cycle=%0d rdy=%b required 0", i, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (wr_cnt != w0 || word_count !== '0) begin
      errors++;
      $display("FAIL idle_ignore writes=%0d wc=%0d required 0 0",
               wr_cnt - w0, word_count);
    end
  endtask

  task automatic test_start_ignored();
    img = '{16'h0101, 16'h0202, 16'h0303};
    run_image(8'h60, 1'b0, 1'b1);
  endtask

  task automatic test_reload();
    img = '{16'hFFFF, 16'h0002};
    run_image(8'h40, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h0001) begin
      errors++;
      $display("FAIL reload_checksum got=%h required 0001", checksum);
    end
`endif
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    int n;
    for (int it = 0; it < 8; it++) begin
      b = AW'($urandom);
      n = $urandom_range(1, MW);
      img.delete();
      for (int k = 0; k < n; k++) img.push_back(DW'($urandom));
      run_image(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_overflow();
    test_reset_midload();
    test_start_ignored();
    test_reload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the cpu. After reset, it receives a program image as a stream of 16-bit words over a valid/ready handshake.
- It writes each word into consecutive ram locations starting at a base address, then releases the cpu from reset with start_pc set to that base.
- It shares the ram write port with the cpu. The ram write mux outside this block selects loader signals whenever cpu_rst_n is low.

Parameters:
- ADDR_W, 8, width of ram address, pc and start_pc.
- DATA_W, 16, width of an instruction/data word.
- MAX_WORDS, 256, maximum words accepted per load (must be ≤ 2**ADDR_W).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- load_base  input  ADDR_W  first ram address of the image; sampled on the start cycle.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  loader accepts a word this cycle.
- in_data  input  DATA_W  program word.
- in_last  input  1  marks the final word of the image.
- ram_w_en  output  1  ram write enable.
- ram_w_addr  output  ADDR_W  ram write address.
- ram_w_data  output  DATA_W  ram write data.
- cpu_rst_n  output  1  active-low reset to the cpu controller; 0 holds the cpu.
- start_pc  output  ADDR_W  pc value for the cpu clear_pc path.
- busy  output  1  high in LOAD and FLUSH.
- done  output  1  high in RUN.
- err_overflow  output  1  high in ERR.
- word_count  output  ADDR_W+1  words accepted in the current or last load.

Behaviour:
- States: IDLE, LOAD, FLUSH, RUN, ERR.
- Reset (rst=1 at an edge), from any state including mid-load:
  - state←IDLE, cpu_rst_n=0.
  - ram_w_en=0, ram_w_addr=0, ram_w_data=0.
  - start_pc=0, word_count=0, busy=0, done=0, err_overflow=0.
- in_ready = (state==LOAD) && (word_count<MAX_WORDS). Combinational; depends on no inputs.
- Handshake: a word is accepted at an edge where in_valid && in_ready. in_data/in_last may change only after acceptance. A word presented in IDLE is ignored.
- IDLE, on start:
  - addr_ptr←load_base, start_pc←load_base, word_count←0 → LOAD.
- LOAD, on accept:
  - Next cycle (registered, latency 1): ram_w_en=1, ram_w_addr=addr_ptr, ram_w_data=in_data.
  - addr_ptr←addr_ptr+1, modulo 2**ADDR_W (0xFF wraps to 0x00).
  - word_count←word_count+1.
  - If in_last → FLUSH.
- LOAD, overflow: in_valid=1 while word_count==MAX_WORDS → ERR. No write occurs.
- ram_w_en is 0 in every cycle that does not follow an accept. Exactly one write per accepted word.
- FLUSH: one cycle, in which the final write occurs; then → RUN.
- RUN: cpu_rst_n=1, done=1. start_pc holds. First cpu cycle is 2 cycles after the in_last accept edge.
- RUN, on start: cpu_rst_n←0 on the next edge and the IDLE start actions apply → LOAD (reload).
- ERR: cpu_rst_n=0, err_overflow=1. Exits only on rst or start; start behaves as in IDLE and clears err_overflow.
- start in LOAD or FLUSH is ignored.
- start coinciding with rst: rst wins.
- Single-word image (in_last on the first accept) is legal: word_count=1.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [DATA_W-1:0]: sum mod 2**DATA_W of accepted words.
  - checksum is cleared to 0 by reset and by an accepted start, and updates on the edge of each accept.
  - Value is stable from FLUSH onward.
- Undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with load_base=0x10; stream 0x1111,0x2222,0x3333 (last on 3rd), valid held high:
  - ram writes at 0x10/0x11/0x12 on cycles accept+1.
  - FLUSH follows the 3rd accept; cpu_rst_n=1, done=1 two cycles after the 3rd accept.
  - start_pc=0x10, word_count=3.
- Backpressure/gaps: toggle in_valid every other cycle during the same stream → identical writes, no duplicates; ram_w_en low in gap cycles.
- Wrap: load_base=0xFE, 4 words → writes at 0xFE,0xFF,0x00,0x01; word_count=4.
- Overflow (MAX_WORDS=4): 5 words with no in_last → 4 writes; in_ready=0 after the 4th; err_overflow=1; cpu_rst_n stays 0; a subsequent start clears the error.
- Reset mid-load after 2 words → IDLE; all outputs at reset values; a later valid word is not accepted until start.
- Reload from RUN: start with load_base=0x40 → cpu_rst_n=0 next cycle; new image written; start_pc=0x40. With LOADER_CHECKSUM_EN, words 0xFFFF,0x0002 give checksum=0x0001.
